// File: rtl/com_pkg.sv
// Shared constants, state encodings and decode helpers for the Ethernet
// command-packet parser.
package com_pkg;

  localparam logic [15:0] STD_HEAD = 16'h55AA;

  localparam logic [15:0] BAG_CONF = 16'h001E;
  localparam logic [15:0] BAG_READ = 16'h004C;
  localparam logic [15:0] BAG_STOP = 16'h0097;
  localparam logic [15:0] BAG_RXD0 = 16'h002D;
  localparam logic [15:0] BAG_RXD1 = 16'h00D2;

  localparam logic [3:0] BTYPE_NONE = 4'd0;
  localparam logic [3:0] BTYPE_CONF = 4'd1;
  localparam logic [3:0] BTYPE_READ = 4'd2;
  localparam logic [3:0] BTYPE_STOP = 4'd3;
  localparam logic [3:0] BTYPE_RXD0 = 4'd4;
  localparam logic [3:0] BTYPE_RXD1 = 4'd5;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_HEAD  = 2'd1;
  localparam logic [1:0] ERR_PASS  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  localparam logic [6:0] ST_IDLE  = 7'b0000001;
  localparam logic [6:0] ST_WAIT  = 7'b0000010;
  localparam logic [6:0] ST_WORK  = 7'b0000100;
  localparam logic [6:0] ST_CHECK = 7'b0001000;
  localparam logic [6:0] ST_TAKE  = 7'b0010000;
  localparam logic [6:0] ST_REST  = 7'b0100000;
  localparam logic [6:0] ST_DONE  = 7'b1000000;

  // Nibble positions used to build com_cmd / trgg_cmd from config words
  localparam int NIB_HI = 8;
  localparam int NIB_LO = 0;

  typedef struct packed {
    logic [3:0]  btype;
    logic [11:0] com_cmd;
    logic [39:0] trgg_cmd;
  } cmd_t;

  function automatic logic [3:0] func_btype(input logic [15:0] f);
    case (f)
      BAG_CONF: return BTYPE_CONF;
      BAG_READ: return BTYPE_READ;
      BAG_STOP: return BTYPE_STOP;
      BAG_RXD0: return BTYPE_RXD0;
      BAG_RXD1: return BTYPE_RXD1;
      default:  return BTYPE_NONE;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/com_if.sv
// RX RAM / packet handshake bundle between the Ethernet receiver and the parser.
interface com_if;
  logic       fs_eth;
  logic       fd_eth;
  logic [7:0] rxa;
  logic [7:0] rxd;

  modport master (output fs_eth, output rxd, input fd_eth, input rxa);
  modport slave  (input fs_eth, input rxd, output fd_eth, output rxa);
endinterface

// File: rtl/com_word_acc.sv
// Byte-to-word assembler: big-endian word store plus running checksum of
// words 1..NUM_WORD-2.
module com_word_acc #(
  parameter  int NUM_WORD = 9,
  localparam int IW       = $clog2(2*NUM_WORD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      byte_vld,
  input  logic [IW-1:0]             byte_idx,
  input  logic [7:0]                rxd,
  output logic [NUM_WORD-1:0][15:0] words,
  output logic [15:0]               sum
);
  localparam logic [IW-2:0] W_LAST = (IW-1)'(NUM_WORD-1);

  logic [NUM_WORD-1:0][15:0] words_q;
  logic [15:0]               sum_q;
  logic [IW-2:0]             w;

  assign w = byte_idx[IW-1:1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      words_q <= '0;
      sum_q   <= '0;
    end else if (byte_vld) begin
      if (!byte_idx[0]) begin
        words_q[w][15:8] <= rxd;
      end else begin
        words_q[w][7:0] <= rxd;
        // Word completes on its low byte; head and checksum word stay out of the sum
        if (w != '0 && w < W_LAST)
          sum_q <= sum_q + {words_q[w][15:8], rxd};
      end
    end
  end

  assign words = words_q;
  assign sum   = sum_q;
endmodule

// File: rtl/com_parse.sv
// Command-packet parser: fetches a packet from the RX RAM, validates it and
// publishes the decoded command to the collect control path.
module com_parse #(
  parameter logic [7:0]  RAM_ADDR_INIT = 8'h0A,
  parameter int          NUM_WORD      = 9,
  parameter int          RAM_LATENCY   = 2,
  parameter logic [15:0] STD_HEAD      = com_pkg::STD_HEAD,
  parameter bit          CHECK_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  com_if.slave        rx,
  output logic        fs,
  input  logic        fd,
  input  logic [15:0] password,
  output logic [3:0]  btype,
  output logic [11:0] com_cmd,
  output logic [39:0] trgg_cmd,
  output logic [1:0]  err,
  output logic [7:0]  err_cnt
);
  import com_pkg::*;

  localparam int CW = $clog2(2*NUM_WORD+RAM_LATENCY+1);
  localparam int IW = $clog2(2*NUM_WORD);
  localparam logic [CW-1:0] CNT_END = CW'(2*NUM_WORD+RAM_LATENCY);
  localparam logic [CW-1:0] CNT_ADR = CW'(2*NUM_WORD);
  localparam logic [CW-1:0] CNT_CAP = CW'(1+RAM_LATENCY);

  logic [6:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rxa_q, rxa_d;
  cmd_t          cmd_q, cmd_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          hp_q, hp_d, pp_q, pp_d, ok_q, ok_d;

  logic                      byte_vld;
  logic [IW-1:0]             byte_idx;
  logic [NUM_WORD-1:0][15:0] words;
  logic [15:0]               sum;
  logic [3:0]                bt;
  logic                      unused_words;

  // Byte k lands RAM_LATENCY+1 cycles after its address was issued
  assign byte_vld = (state_q == ST_WORK) && (cnt_q >= CNT_CAP);
  assign byte_idx = IW'(cnt_q - CNT_CAP);
  assign bt       = func_btype(words[2]);
  assign unused_words = ^words;

  com_word_acc #(.NUM_WORD(NUM_WORD)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == ST_WAIT),
    .byte_vld (byte_vld),
    .byte_idx (byte_idx),
    .rxd      (rx.rxd),
    .words    (words),
    .sum      (sum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    rxa_d     = RAM_ADDR_INIT;
    cmd_d     = cmd_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    hp_d      = hp_q;
    pp_d      = pp_q;
    ok_d      = ok_q;
    case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: if (rx.fs_eth) state_d = ST_WORK;
      ST_WORK: begin
        if (!rx.fs_eth) begin
          state_d   = ST_WAIT;
          err_d     = ERR_ABORT;
          err_cnt_d = sat_inc8(err_cnt_q);
        end else if (cnt_q == CNT_END) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
          rxa_d = (cnt_q < CNT_ADR) ? RAM_ADDR_INIT + 8'(cnt_q) : rxa_q;
        end
      end
      ST_CHECK: begin
        hp_d    = !CHECK_EN || (words[0] == STD_HEAD && sum == words[NUM_WORD-1]);
        pp_d    = (bt != BTYPE_NONE) && (!CHECK_EN || words[1] == password);
        state_d = ST_TAKE;
      end
      ST_TAKE: begin
        ok_d = hp_q && pp_q;
        if (hp_q && pp_q) begin
          cmd_d.btype = bt;
          err_d       = ERR_OK;
          if (bt == BTYPE_CONF) begin
            cmd_d.com_cmd  = {words[3][NIB_LO+:4], words[4][NIB_HI+:4], words[4][NIB_LO+:4]};
            cmd_d.trgg_cmd = {words[5][NIB_HI+:4], words[5][NIB_LO+:4], words[6], words[7]};
          end
        end else begin
          err_d     = hp_q ? ERR_PASS : ERR_HEAD;
          err_cnt_d = sat_inc8(err_cnt_q);
        end
        state_d = ST_REST;
      end
      ST_REST: if (!rx.fs_eth) state_d = ok_q ? ST_DONE : ST_WAIT;
      ST_DONE: if (fd) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rxa_q     <= RAM_ADDR_INIT;
      cmd_q     <= '0;
      err_q     <= ERR_OK;
      err_cnt_q <= '0;
      hp_q      <= 1'b0;
      pp_q      <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rxa_q     <= rxa_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      hp_q      <= hp_d;
      pp_q      <= pp_d;
      ok_q      <= ok_d;
    end
  end

  assign rx.rxa    = rxa_q;
  assign rx.fd_eth = (state_q == ST_REST);
  assign fs        = (state_q == ST_DONE);
  assign btype     = cmd_q.btype;
  assign com_cmd   = cmd_q.com_cmd;
  assign trgg_cmd  = cmd_q.trgg_cmd;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_com_parse.sv
// Bench for com_parse: default, CHECK_EN=0 and NUM_WORD=12/RAM_LATENCY=3
// instances, each fed from its own RX RAM model with matching read latency.
module tb_com_parse;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       fs_eth_w, fd_w, fd_eth_w, fs_w;
  logic [2:0][15:0] pw_w;
  logic [2:0][7:0]  rxa_w, rxd_w, ec_w;
  logic [2:0][3:0]  bt_w;
  logic [2:0][11:0] cc_w;
  logic [2:0][39:0] tc_w;
  logic [2:0][1:0]  er_w;

  com_if ifa(), ifb(), ifc();
  assign ifa.fs_eth = fs_eth_w[0];
  assign ifb.fs_eth = fs_eth_w[1];
  assign ifc.fs_eth = fs_eth_w[2];
  assign ifa.rxd = rxd_w[0];
  assign ifb.rxd = rxd_w[1];
  assign ifc.rxd = rxd_w[2];
  assign fd_eth_w = {ifc.fd_eth, ifb.fd_eth, ifa.fd_eth};
  assign rxa_w    = {ifc.rxa, ifb.rxa, ifa.rxa};

  com_parse u_a (.clk(clk), .rst(rst), .rx(ifa), .fs(fs_w[0]), .fd(fd_w[0]),
    .password(pw_w[0]), .btype(bt_w[0]), .com_cmd(cc_w[0]), .trgg_cmd(tc_w[0]),
    .err(er_w[0]), .err_cnt(ec_w[0]));
  com_parse #(.CHECK_EN(1'b0)) u_b (.clk(clk), .rst(rst), .rx(ifb), .fs(fs_w[1]), .fd(fd_w[1]),
    .password(pw_w[1]), .btype(bt_w[1]), .com_cmd(cc_w[1]), .trgg_cmd(tc_w[1]),
    .err(er_w[1]), .err_cnt(ec_w[1]));
  com_parse #(.NUM_WORD(12), .RAM_LATENCY(3)) u_c (.clk(clk), .rst(rst), .rx(ifc), .fs(fs_w[2]),
    .fd(fd_w[2]), .password(pw_w[2]), .btype(bt_w[2]), .com_cmd(cc_w[2]), .trgg_cmd(tc_w[2]),
    .err(er_w[2]), .err_cnt(ec_w[2]));

  // RX RAM models: registered read chain, tapped at each instance's latency
  logic [7:0] mem [3][256];
  logic [7:0] rp  [3][3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rp[i][0] <= mem[i][rxa_w[i]];
      rp[i][1] <= rp[i][0];
      rp[i][2] <= rp[i][1];
    end
  end
  assign rxd_w[0] = rp[0][1];
  assign rxd_w[1] = rp[1][1];
  assign rxd_w[2] = rp[2][2];

  typedef struct packed {
    logic [3:0] bt; logic [11:0] cc; logic [39:0] tc; logic [1:0] er; logic [7:0] ec;
  } exp_t;

  int          nvec = 0, nmis = 0;
  int          NWA[3]  = '{9, 9, 12};
  int          LATA[3] = '{2, 2, 3};
  bit          CEA[3]  = '{1'b1, 1'b0, 1'b1};
  exp_t        mdl[3];
  exp_t        sbq[$];
  logic [15:0] pkt[64];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic mk_conf(input int nw, input logic [15:0] w1, input logic [15:0] delta);
    pkt[0] = 16'h55AA; pkt[1] = w1;      pkt[2] = 16'h001E; pkt[3] = 16'h0003;
    pkt[4] = 16'h0A05; pkt[5] = 16'h0102; pkt[6] = 16'h1234; pkt[7] = 16'h5678;
    for (int i = 8; i <= nw - 2; i++) pkt[i] = 16'((i - 7) * 'h1111);
    pkt[nw-1] = ((nw == 9) ? 16'h32C3 : 16'h9929) + delta;
  endtask

  task automatic mk_read(input logic [15:0] w1);
    pkt[0] = 16'h55AA; pkt[1] = w1; pkt[2] = 16'h004C;
    for (int i = 3; i < 8; i++) pkt[i] = 16'h0000;
    pkt[8] = 16'(w1 + 16'h004C);
  endtask

  // Reference model of the packet verdict; result goes to the scoreboard
  task automatic predict(input int id, input bit abort, output bit ok);
    exp_t e = mdl[id];
    logic [15:0] s = '0;
    logic [3:0] b;
    bit hp, pp;
    int nw = NWA[id];
    ok = 1'b0;
    if (abort) begin
      e.er = 2'd3; e.ec = sat8(e.ec);
    end else begin
      for (int i = 1; i <= nw - 2; i++) s = s + pkt[i];
      case (pkt[2])
        16'h001E: b = 4'd1;  16'h004C: b = 4'd2;  16'h0097: b = 4'd3;
        16'h002D: b = 4'd4;  16'h00D2: b = 4'd5;  default:  b = 4'd0;
      endcase
      hp = !CEA[id] || (pkt[0] == 16'h55AA && s == pkt[nw-1]);
      pp = (b != 4'd0) && (!CEA[id] || pkt[1] == pw_w[id]);
      if (hp && pp) begin
        ok = 1'b1; e.bt = b; e.er = 2'd0;
        if (b == 4'd1) begin
          e.cc = {pkt[3][3:0], pkt[4][11:8], pkt[4][3:0]};
          e.tc = {pkt[5][11:8], pkt[5][3:0], pkt[6], pkt[7]};
        end
      end else begin
        e.er = hp ? 2'd2 : 2'd1; e.ec = sat8(e.ec);
      end
    end
    mdl[id] = e;
    sbq.push_back(e);
  endtask

  task automatic run_pkt(input int id, input int drop_at, input bit chk_len);
    bit ok, seen;
    int n, rbad, m, nw2, lat;
    logic [7:0] ea;
    exp_t e;
    nw2 = 2 * NWA[id]; lat = LATA[id];
    for (int i = 0; i < NWA[id]; i++) begin
      mem[id][8'h0A + 2*i]     = pkt[i][15:8];
      mem[id][8'h0A + 2*i + 1] = pkt[i][7:0];
    end
    predict(id, drop_at > 0, ok);
    repeat (3) tick();
    fs_eth_w[id] = 1'b1;
    n = 0; rbad = 0; seen = 1'b0;
    while (n < 200) begin
      tick(); n++;
      if (fd_eth_w[id]) begin seen = 1'b1; break; end
      if (drop_at > 0) begin
        if (n == drop_at) fs_eth_w[id] = 1'b0;
        if (n > drop_at + 2) break;
      end
      m = n - 1;
      if (m == 0 || m > nw2 + lat) ea = 8'h0A;
      else if (m <= nw2)           ea = 8'(8'h0A + m - 1);
      else                         ea = 8'(8'h0A + nw2 - 1);
      if (rxa_w[id] !== ea) rbad++;
    end
    chk("rest_seen", seen, drop_at == 0);
    if (chk_len) begin
      chk("work_len", n - 3, nw2 + lat + 1);
      chk("rxa_sweep_bad", rbad, 0);
    end
    e = sbq.pop_front();
    chk("btype", bt_w[id], e.bt);
    chk("com_cmd", cc_w[id], e.cc);
    chk("trgg_cmd", tc_w[id], e.tc);
    chk("err", er_w[id], e.er);
    chk("err_cnt", ec_w[id], e.ec);
    if (drop_at == 0) begin
      fs_eth_w[id] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (fs_w[id]) seen = 1'b1;
      end
      chk("fs_raise", seen, ok);
      chk("fd_eth_release", fd_eth_w[id], 1'b0);
      if (ok) begin
        chk("fs_hold", fs_w[id], 1'b1);
        fd_w[id] = 1'b1; tick(); fd_w[id] = 1'b0;
        chk("fs_drop", fs_w[id], 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; fs_eth_w = '0; fd_w = '0;
    pw_w = {16'hBEEF, 16'hBEEF, 16'hBEEF};
    for (int i = 0; i < 3; i++) begin
      mdl[i] = '0;
      for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_rxa", rxa_w[i], 8'h0A);
      chk("rst_out", {bt_w[i], cc_w[i], tc_w[i], er_w[i], ec_w[i], fs_w[i], fd_eth_w[i]}, 0);
    end
    rst = 1'b0;

    mk_conf(9, 16'hBEEF, 16'h0000);
    run_pkt(0, 0, 1'b1);
    chk("conf_btype", bt_w[0], 4'd1);
    chk("conf_com_cmd", cc_w[0], 12'h3A5);
    chk("conf_trgg_cmd", tc_w[0], 40'h12_1234_5678);

    mk_conf(9, 16'hBEEF, 16'h0001);
    run_pkt(0, 0, 1'b0);
    chk("bad_sum_err", er_w[0], 2'd1);
    chk("bad_sum_errcnt", ec_w[0], 8'd1);
    run_pkt(1, 0, 1'b0);
    chk("nocheck_btype", bt_w[1], 4'd1);
    chk("nocheck_com_cmd", cc_w[1], 12'h3A5);

    mk_read(16'hBEEE);
    run_pkt(0, 0, 1'b0);
    chk("pw_err", er_w[0], 2'd2);
    mk_read(16'hBEEF);
    run_pkt(0, 0, 1'b0);
    chk("read_btype", bt_w[0], 4'd2);
    chk("read_com_hold", cc_w[0], 12'h3A5);

    mk_conf(9, 16'hBEEF, 16'h0000);
    run_pkt(0, 8, 1'b0);
    chk("abort_err", er_w[0], 2'd3);

    // Reset in the middle of WORK
    repeat (3) tick();
    fs_eth_w[0] = 1'b1;
    repeat (8) tick();
    rst = 1'b1; tick();
    chk("midrst_rxa", rxa_w[0], 8'h0A);
    chk("midrst_out", {bt_w[0], cc_w[0], tc_w[0], er_w[0], ec_w[0], fs_w[0], fd_eth_w[0]}, 0);
    rst = 1'b0; fs_eth_w[0] = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = '0;

    mk_conf(12, 16'hBEEF, 16'h0000);
    run_pkt(2, 0, 1'b1);
    chk("nw12_btype", bt_w[2], 4'd1);
    chk("nw12_trgg", tc_w[2], 40'h12_1234_5678);

    mk_conf(12, 16'hBEEF, 16'h0100);
    for (int p = 0; p < 256; p++) run_pkt(2, 0, 1'b0);
    chk("errcnt_sat", ec_w[2], 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
